// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter for eight level-held requesters with a registered one-hot grant.
// Optional forced release after HOLD_MAX cycles is compiled in with `define ARB_TIMEOUT_EN.
module rr_grant_arbiter #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       rel,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    // state | meaning
    // IDLE  | no owner; arbitrate on the next edge if any req bit is set
    // BUSY  | owner gnt_idx holds the grant until rel, dropped req or hold limit
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("rr_grant_arbiter: HOLD_MAX must be within 1..255");
    end

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] win_idx;
    logic [2:0] cand;
    logic       win_found;
    logic       rel_normal;
    logic       rel_forced;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       tmo_q, tmo_d;
`endif

    // First set bit at or after ptr; scanning offsets high-to-low lets the nearest one win.
    always_comb begin
        win_idx   = ptr_q;
        win_found = 1'b0;
        cand      = ptr_q;
        for (int i = 7; i >= 0; i--) begin
            cand = ptr_q + 3'(i);
            if (req[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    assign rel_normal = rel | ~req[idx_q];

`ifdef ARB_TIMEOUT_EN
    assign rel_forced = (hold_q == 8'(HOLD_MAX - 1));
`else
    assign rel_forced = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            idx_q   <= 3'd0;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= 8'd0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= hold_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
`ifdef ARB_TIMEOUT_EN
        hold_d  = hold_q;
        tmo_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = BUSY;
                    idx_d   = win_idx;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = 8'd0;
`endif
                end
            end
            BUSY: begin
                if (rel_normal || rel_forced) begin
                    state_d = IDLE;
                    ptr_d   = idx_q + 3'd1;
`ifdef ARB_TIMEOUT_EN
                    hold_d  = 8'd0;
                    tmo_d   = ~rel_normal;
`endif
                end else begin
`ifdef ARB_TIMEOUT_EN
                    hold_d  = hold_q + 8'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_valid = (state_q == BUSY);
        gnt_idx   = idx_q;
        gnt       = gnt_valid ? (8'b1 << idx_q) : 8'h00;
`ifdef ARB_TIMEOUT_EN
        timeout   = tmo_q;
`else
        timeout   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed and random checks of rr_grant_arbiter against an owner/pointer reference model.
// Build with +define+ARB_TIMEOUT_EN to exercise the forced-release path (HOLD_MAX=4).
module tb_rr_grant_arbiter;

    localparam int HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       rel = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int vectors = 0;
    int miscompares = 0;

    // reference model: owner is -1 when nobody holds the grant
    int m_owner = -1;
    int m_ptr   = 0;
    int m_last  = 0;
    int m_held  = 0;
    bit m_tmo   = 1'b0;

    rr_grant_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .rel(rel),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input logic [7:0] r, input logic rl, input logic rs);
        bit normal, timed;
        if (rs) begin
            m_owner = -1; m_ptr = 0; m_last = 0; m_held = 0; m_tmo = 1'b0;
        end else if (m_owner < 0) begin
            m_tmo = 1'b0;
            for (int k = 0; k < 8; k++) begin
                int j;
                j = (m_ptr + k) % 8;
                if (r[j]) begin
                    m_owner = j; m_last = j; m_held = 1;
                    break;
                end
            end
        end else begin
            normal = rl || !r[m_owner];
            timed  = TMO_EN && (m_held >= HOLD);
            if (normal || timed) begin
                m_ptr   = (m_owner + 1) % 8;
                m_tmo   = timed && !normal;
                m_owner = -1;
            end else begin
                m_tmo  = 1'b0;
                m_held = m_held + 1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] e_gnt;
        e_gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        vectors++;
        assert (gnt === e_gnt) else begin
            miscompares++;
            $error("FAIL %s gnt got %h exp %h", tag, gnt, e_gnt);
        end
        vectors++;
        assert (gnt_idx === 3'(m_last)) else begin
            miscompares++;
            $error("FAIL %s gnt_idx got %0d exp %0d", tag, gnt_idx, m_last);
        end
        vectors++;
        assert (gnt_valid === (m_owner >= 0)) else begin
            miscompares++;
            $error("FAIL %s gnt_valid got %b exp %b", tag, gnt_valid, (m_owner >= 0));
        end
        vectors++;
        assert (timeout === m_tmo) else begin
            miscompares++;
            $error("FAIL %s timeout got %b exp %b", tag, timeout, m_tmo);
        end
    endtask

    task automatic step(input logic [7:0] r, input logic rl, input logic rs, input string tag);
        @(negedge clk);
        req = r; rel = rl; rst = rs;
        @(posedge clk);
        model_edge(r, rl, rs);
        #1;
        check_model(tag);
    endtask

    task automatic expect_gnt(input logic [7:0] e, input logic et, input string tag);
        vectors++;
        assert (gnt === e && timeout === et) else begin
            miscompares++;
            $error("FAIL %s gnt/timeout got %h/%b exp %h/%b", tag, gnt, timeout, e, et);
        end
    endtask

    initial begin
        step(8'h00, 1'b0, 1'b1, "reset0");
        step(8'hFF, 1'b1, 1'b1, "reset1");
        expect_gnt(8'h00, 1'b0, "reset_out");

        // basic grant, release, rotate to 7, wrap back to 0
        step(8'h81, 1'b0, 1'b0, "g0");     expect_gnt(8'h01, 1'b0, "first_g0");
        step(8'h81, 1'b1, 1'b0, "rel0");   expect_gnt(8'h00, 1'b0, "gap0");
        step(8'h81, 1'b0, 1'b0, "g7");     expect_gnt(8'h80, 1'b0, "next_g7");
        step(8'h81, 1'b1, 1'b0, "rel7");   expect_gnt(8'h00, 1'b0, "gap7");
        step(8'h81, 1'b0, 1'b0, "wrap");   expect_gnt(8'h01, 1'b0, "wrap_g0");
        step(8'h00, 1'b1, 1'b0, "rel_all");
        step(8'h00, 1'b1, 1'b0, "rel_idle");

        // full rotation with every requester asserted
        step(8'h00, 1'b0, 1'b1, "rst_ff");
        for (int k = 0; k < 9; k++) begin
            step(8'hFF, 1'b0, 1'b0, "ff_grant");
            expect_gnt(8'h01 << (k % 8), 1'b0, "ff_order");
            step(8'hFF, 1'b1, 1'b0, "ff_rel");
            expect_gnt(8'h00, 1'b0, "ff_gap");
        end

        // owner drops its request
        step(8'h00, 1'b0, 1'b1, "rst_drop");
        step(8'h08, 1'b0, 1'b0, "g3");     expect_gnt(8'h08, 1'b0, "own3");
        step(8'h10, 1'b0, 1'b0, "drop3");  expect_gnt(8'h00, 1'b0, "drop3_gap");
        step(8'h10, 1'b0, 1'b0, "g4");     expect_gnt(8'h10, 1'b0, "own4");

        // reset mid-grant
        step(8'h00, 1'b0, 1'b1, "rst_mid0");
        step(8'h20, 1'b0, 1'b0, "g5");     expect_gnt(8'h20, 1'b0, "own5");
        step(8'h24, 1'b0, 1'b1, "rst_mid"); expect_gnt(8'h00, 1'b0, "rst_drop_out");
        step(8'h24, 1'b0, 1'b0, "after_rst"); expect_gnt(8'h04, 1'b0, "after_rst_g2");

        // hold limit behaviour
        step(8'h00, 1'b0, 1'b1, "rst_hold");
        step(8'h03, 1'b0, 1'b0, "h_g0");
        for (int k = 1; k < HOLD; k++) step(8'h03, 1'b0, 1'b0, "h_hold");
        expect_gnt(8'h01, 1'b0, "hold_last");
        step(8'h03, 1'b0, 1'b0, "h_limit");
        if (TMO_EN) begin
            expect_gnt(8'h00, 1'b1, "tmo_pulse");
            step(8'h03, 1'b0, 1'b0, "h_g1");
            expect_gnt(8'h02, 1'b0, "tmo_next_g1");
        end else begin
            for (int k = 0; k < 8; k++) step(8'h03, 1'b0, 1'b0, "h_forever");
            expect_gnt(8'h01, 1'b0, "held_forever");
        end

        // normal release coinciding with the limit
        step(8'h00, 1'b0, 1'b1, "rst_coinc");
        step(8'h01, 1'b0, 1'b0, "c_g0");
        for (int k = 1; k < HOLD; k++) step(8'h01, 1'b0, 1'b0, "c_hold");
        step(8'h01, 1'b1, 1'b0, "c_rel");
        expect_gnt(8'h00, 1'b0, "coinc_no_tmo");

        // random traffic
        for (int n = 0; n < 600; n++) begin
            logic [7:0] r;
            r = 8'($urandom) & 8'($urandom);
            step(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 60) == 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_grant_arbiter.md
RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 16, maximum grant hold in cycles; range 1..255; used only when ARB_TIMEOUT_EN is defined.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: req  input  8  request vector; bit i is requester i, level-held.
REQ-006 Port: rel  input  1  release strobe from current owner, sampled on clk.
REQ-007 Port: gnt  output  8  one-hot grant; 3-to-8 decode of gnt_idx gated by gnt_valid.
REQ-008 Port: gnt_idx  output  3  binary index of current owner.
REQ-009 Port: gnt_valid  output  1  a grant is active.
REQ-010 Port: timeout  output  1  one-cycle pulse on forced release.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE (no owner) and BUSY (owner held).
REQ-012 Priority pointer ptr, 3 bits: search order SHALL be ptr, ptr+1, ..., ptr+7, modulo 8.
REQ-013 IDLE, req != 0 at an edge: first set bit in search order becomes owner; gnt_idx, gnt_valid=1 and BUSY are registered at that edge (grant visible one cycle after req is sampled).
REQ-014 IDLE, req == 0: outputs SHALL stay at gnt_valid=0, gnt=0; gnt_idx holds its last value.
REQ-015 gnt SHALL equal 8'h00 when gnt_valid=0, else exactly one bit set at position gnt_idx; no other output combination is legal.
REQ-016 BUSY: grant SHALL be held unchanged while req[gnt_idx]=1 and rel=0, regardless of other req bits.
REQ-017 BUSY, rel=1 or req[gnt_idx]=0 at an edge: gnt_valid->0, state->IDLE, ptr->gnt_idx+1 (7 wraps to 0).
REQ-018 After any release, at least one cycle SHALL have gnt_valid=0 before the next grant (no back-to-back handover).
REQ-019 Release and new requests in the same cycle: release SHALL win; the new arbitration SHALL occur in IDLE on the next edge.
REQ-020 rel while IDLE SHALL be ignored.
REQ-021 A requester SHALL never be granted twice while another requester that was continuously requesting was skipped (round-robin fairness, worst-case wait 7 grants).

Reset
REQ-022 rst=1 at an edge SHALL force state IDLE, ptr=0, gnt_idx=0, gnt_valid=0, gnt=0, timeout=0, hold counter=0, overriding all other inputs.
REQ-023 Reset asserted during BUSY SHALL drop the grant at that edge; the first grant after reset SHALL search from index 0.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN defined: an 8-bit hold counter clears on each grant and increments each BUSY cycle; when the owner has held the grant for HOLD_MAX cycles without releasing, the block SHALL force the release per REQ-017 and pulse timeout=1 for exactly that cycle.
REQ-025 A normal release (rel or dropped req) occurring on the same edge as the limit SHALL take precedence; timeout SHALL stay 0.
REQ-026 Macro ARB_TIMEOUT_EN undefined: there SHALL be no hold counter, timeout SHALL be tied to 0, and grants SHALL be held indefinitely.

Verification
REQ-027 After reset, req=8'h81 -> next cycle gnt=8'h01, gnt_idx=0; rel pulse -> gnt=8'h00 for one cycle, then gnt=8'h80, gnt_idx=7.
REQ-028 Owner 7 releases with req=8'h81 held -> ptr wraps to 0; next grant gnt=8'h01.
REQ-029 req=8'hFF held, rel pulsed after each grant -> grant order 0,1,...,7,0 with exactly one idle cycle between grants.
REQ-030 Owner 3 granted, req[3] drops while req=8'h10 -> grant released, then gnt=8'h10.
REQ-031 rst=1 mid-grant with gnt=8'h20 -> all outputs 0 at that edge; after rst=0 with req=8'h24 -> gnt=8'h04.
REQ-032 ARB_TIMEOUT_EN, HOLD_MAX=4, req=8'h03, no rel -> owner 0 held 4 cycles, timeout=1 for one cycle, one idle cycle, then gnt=8'h02; with the macro undefined -> gnt=8'h01 held indefinitely, timeout=0.
